// File: rtl/io_arbiter.sv
// Two-master round-robin arbiter that sequences one registered IO strobe per grant
// and returns a one-cycle acknowledge with read data and an error flag.
module io_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'd23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        io_write_en,
    output logic        io_read_en,
    output logic [31:0] io_addr,
    output logic [15:0] io_wr_data,
    input  logic [31:0] io_rd_data,
    input  logic        io_vld,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        ptr;
    logic        gnt;
    logic        we_q;
    logic        err_q;
    logic        any_req;
    logic        winner;
    logic        win_we;
    logic [31:0] win_addr;
    logic [15:0] win_wdata;
    logic        range_err;
    logic [31:0] resp_data;
    logic        resp_err;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        any_req   = m0_req | m1_req;
        winner    = (m0_req & m1_req) ? ptr : m1_req;
        win_we    = winner ? m1_we    : m0_we;
        win_addr  = winner ? m1_addr  : m0_addr;
        win_wdata = winner ? m1_wdata : m0_wdata;
        range_err = (win_addr > ADDR_LIMIT);
        resp_err  = err_q | (~we_q & ~io_vld);
        resp_data = (~we_q & ~err_q & io_vld) ? io_rd_data : 32'd0;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= 1'b0;
            gnt         <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            io_addr     <= 32'd0;
            io_wr_data  <= 16'd0;
            io_write_en <= 1'b0;
            io_read_en  <= 1'b0;
            m0_ack      <= 1'b0;
            m0_rdata    <= 32'd0;
            m0_err      <= 1'b0;
            m1_ack      <= 1'b0;
            m1_rdata    <= 32'd0;
            m1_err      <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses unless re-armed below.
            io_write_en <= 1'b0;
            io_read_en  <= 1'b0;
            m0_ack      <= 1'b0;
            m0_rdata    <= 32'd0;
            m0_err      <= 1'b0;
            m1_ack      <= 1'b0;
            m1_rdata    <= 32'd0;
            m1_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt         <= winner;
                        ptr         <= ~winner;
                        we_q        <= win_we;
                        err_q       <= range_err;
                        io_addr     <= win_addr;
                        io_wr_data  <= win_wdata;
                        io_write_en <= win_we & ~range_err;
                        io_read_en  <= ~win_we & ~range_err;
                    end
                end
                ACCESS: begin
                    if (gnt) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= resp_data;
                        m1_err   <= resp_err;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= resp_data;
                        m0_err   <= resp_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: table of single transactions plus hand-written
// reset-abort and contention sequences.
module tb_io_arbiter;

    localparam logic [31:0] RD_ADDR = 32'd19;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [15:0] m1_wdata = '0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        io_write_en, io_read_en, busy;
    logic [31:0] io_addr;
    logic [15:0] io_wr_data;
    logic [31:0] io_rd_data = '0;
    logic        io_vld;

    int n_checks = 0;
    int n_fail   = 0;

    // IO block model: only the switch/button address validates a read.
    assign io_vld = (io_addr == RD_ADDR);

    always #5 clk = ~clk;

    io_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_addr(io_addr), .io_wr_data(io_wr_data),
        .io_rd_data(io_rd_data), .io_vld(io_vld), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        master;
        logic        we;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic [31:0] rd_word;
        logic        exp_wr;
        logic        exp_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic set_master(input logic m, input logic req, input logic we,
                              input logic [31:0] addr, input logic [15:0] wdata);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic g_ack, o_ack, g_err, o_err;
        logic [31:0] g_rdata, o_rdata;
        @(negedge clk);
        io_rd_data = v.rd_word;
        set_master(v.master, 1'b1, v.we, v.addr, v.wdata);
        #1;
        check("no_strobe_with_req", 32'(io_write_en | io_read_en), 32'd0);
        @(posedge clk); #1;
        check("write_en", 32'(io_write_en), 32'(v.exp_wr));
        check("read_en", 32'(io_read_en), 32'(v.exp_rd));
        check("busy_access", 32'(busy), 32'd1);
        check("no_ack_access", 32'(m0_ack | m1_ack), 32'd0);
        if (v.exp_wr | v.exp_rd) check("io_addr", io_addr, v.addr);
        if (v.exp_wr) check("io_wr_data", 32'(io_wr_data), 32'(v.wdata));
        @(posedge clk); #1;
        g_ack   = v.master ? m1_ack   : m0_ack;
        o_ack   = v.master ? m0_ack   : m1_ack;
        g_err   = v.master ? m1_err   : m0_err;
        o_err   = v.master ? m0_err   : m1_err;
        g_rdata = v.master ? m1_rdata : m0_rdata;
        o_rdata = v.master ? m0_rdata : m1_rdata;
        check("strobe_single_cycle", 32'(io_write_en | io_read_en), 32'd0);
        check("ack", 32'(g_ack), 32'd1);
        check("rdata", g_rdata, v.exp_rdata);
        check("err", 32'(g_err), 32'(v.exp_err));
        check("other_quiet", {o_rdata[31:2], o_rdata[1:0] | {o_ack, o_err}}, 32'd0);
        @(negedge clk);
        set_master(v.master, 1'b0, 1'b0, 32'd0, 16'd0);
        @(posedge clk); #1;
        check("ack_single_cycle", 32'(m0_ack | m1_ack), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int acks, last_cyc, strobes;
        logic prev_strobe, cur_strobe;

        //          m  we  addr           wdata     rd_word        wr  rd  rdata          err
        vecs[0] = '{1'b0, 1'b1, 32'd0,        16'hA5A5, 32'd0,         1'b1, 1'b0, 32'd0,         1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'd19,       16'h0000, 32'h0004_1234, 1'b0, 1'b1, 32'h0004_1234, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'd11,       16'h0000, 32'h0000_BEEF, 1'b0, 1'b1, 32'd0,         1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'd40,       16'h5555, 32'd0,         1'b0, 1'b0, 32'd0,         1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'd23,       16'h1234, 32'd0,         1'b1, 1'b0, 32'd0,         1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'd24,       16'h0000, 32'h0000_0007, 1'b0, 1'b0, 32'd0,         1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 16'h0000, 32'h0000_0001, 1'b0, 1'b0, 32'd0,        1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_strobes", 32'(io_write_en | io_read_en), 32'd0);
        check("rst_acks_errs", 32'({m0_ack, m1_ack, m0_err, m1_err, busy}), 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        check("rst_io_addr", io_addr, 32'd0);
        check("rst_io_wr_data", 32'(io_wr_data), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort mid-transaction: m0 grant would move the pointer to 1.
        @(negedge clk);
        set_master(1'b0, 1'b1, 1'b1, 32'd5, 16'hCAFE);
        @(posedge clk); #1;
        check("abort_write_en_up", 32'(io_write_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_write_en_drop", 32'(io_write_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("abort_no_ack", 32'(m0_ack | m1_ack), 32'd0);
        @(negedge clk);
        set_master(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_late_ack", 32'(m0_ack | m1_ack), 32'd0);
        end

        // Contention: the first grant going to m0 also confirms the pointer reset.
        @(negedge clk);
        set_master(1'b0, 1'b1, 1'b1, 32'd1, 16'h1111);
        set_master(1'b1, 1'b1, 1'b1, 32'd2, 16'h2222);
        acks = 0; last_cyc = 0; strobes = 0; prev_strobe = 1'b0;
        for (int cyc = 0; cyc < 30 && acks < 4; cyc++) begin
            @(posedge clk); #1;
            cur_strobe = io_write_en | io_read_en;
            check("strobe_exclusive", 32'(io_write_en & io_read_en), 32'd0);
            check("strobe_not_back_to_back", 32'(prev_strobe & cur_strobe), 32'd0);
            prev_strobe = cur_strobe;
            if (io_write_en) begin
                check("contention_io_addr", io_addr, (strobes % 2 == 0) ? 32'd1 : 32'd2);
                strobes++;
            end
            if (m0_ack | m1_ack) begin
                check("never_both_acks", 32'(m0_ack & m1_ack), 32'd0);
                check("grant_order", 32'(m1_ack), 32'(acks % 2));
                if (acks > 0) check("ack_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                acks++;
            end
        end
        check("contention_acks_seen", 32'(acks), 32'd4);
        @(negedge clk);
        set_master(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        set_master(1'b1, 1'b0, 1'b0, 32'd0, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        check("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
